cpu_alu_seq: RTL and testbench

CPU_ALU_SEQ -- requirements
Module: cpu_alu_seq

---
 rtl/cpu_alu_pkg.sv | 24 ++
 rtl/cpu_alu_mul_iter.sv | 51 +++++
 rtl/cpu_alu_seq.sv | 142 ++++++++++++++
 tb/tb_cpu_alu_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// rtl/cpu_alu_pkg.sv - shared op encodings, flag indices and FSM states for cpu_alu_seq
package cpu_alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_OR  = 8'h08;
    localparam logic [7:0] OP_XOR = 8'h10;
    localparam logic [7:0] OP_SHL = 8'h20;
    localparam logic [7:0] OP_SHR = 8'h40;
    localparam logic [7:0] OP_MUL = 8'h80;

    // FLAGS is packed as {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/cpu_alu_mul_iter.sv
// rtl/cpu_alu_mul_iter.sv - shift-add multiplier, one multiplier bit per cycle
module cpu_alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic                 active;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;

    // product is the accumulator after the current step, so the caller can
    // capture the final value on the same edge that finishes the last step
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = active && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_alu_seq.sv
// rtl/cpu_alu_seq.sv - sequential ALU with valid/ready handshake and iterative multiply
module cpu_alu_seq
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [7:0]        ICNT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WIDTH-1:0]  OUT,
    output logic [3:0]        FLAGS,
    output logic              ERR,
    output logic              BUSY
);

    localparam int MSB = WIDTH - 1;
    localparam int SW  = $clog2(WIDTH);

    state_t               state, state_nxt;
    logic                 accept, mul_start, mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH-1:0]     res_c;
    logic [3:0]           flg_c, mul_flg;
    logic                 c_c, v_c, err_c;
    logic [SW-1:0]        shamt;
    logic [WIDTH:0]       add_w, sub_w, shl_w, shr_w;

    assign IN_READY  = (state == ST_IDLE) && (!OUT_VALID || OUT_READY);
    assign accept    = IN_VALID && IN_READY;
    assign mul_start = accept && (ICNT == OP_MUL);
    assign BUSY      = (state == ST_MUL);

    // extra top bit of each wide result carries carry/borrow/shifted-out bit
    assign shamt = B[SW-1:0];
    assign add_w = {1'b0, A} + {1'b0, B};
    assign sub_w = {1'b0, A} - {1'b0, B};
    assign shl_w = {1'b0, A} << shamt;
    assign shr_w = {A, 1'b0} >> shamt;

    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        err_c = 1'b0;
        case (ICNT)
            OP_ADD: begin
                res_c = add_w[WIDTH-1:0];
                c_c   = add_w[WIDTH];
                v_c   = (A[MSB] == B[MSB]) && (res_c[MSB] != A[MSB]);
            end
            OP_SUB: begin
                res_c = sub_w[WIDTH-1:0];
                c_c   = sub_w[WIDTH];
                v_c   = (A[MSB] != B[MSB]) && (res_c[MSB] != A[MSB]);
            end
            OP_AND: res_c = A & B;
            OP_OR:  res_c = A | B;
            OP_XOR: res_c = A ^ B;
            OP_SHL: begin
                res_c = shl_w[WIDTH-1:0];
                c_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                res_c = shr_w[WIDTH:1];
                c_c   = shr_w[0];
            end
            OP_MUL: ;
            default: err_c = 1'b1;
        endcase
        flg_c = '0;
        if (!err_c) begin
            flg_c[FLAG_Z] = (res_c == '0);
            flg_c[FLAG_N] = res_c[MSB];
            flg_c[FLAG_C] = c_c;
            flg_c[FLAG_V] = v_c;
        end
    end

    always_comb begin
        mul_flg         = '0;
        mul_flg[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
        mul_flg[FLAG_N] = mul_product[MSB];
        mul_flg[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
    end

    cpu_alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (CLK),
        .rst     (RST),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT       <= '0;
            FLAGS     <= '0;
            ERR       <= 1'b0;
        end else if (mul_done) begin
            OUT_VALID <= 1'b1;
            OUT       <= mul_product[WIDTH-1:0];
            FLAGS     <= mul_flg;
            ERR       <= 1'b0;
        end else if (accept && !mul_start) begin
            OUT_VALID <= 1'b1;
            OUT       <= res_c;
            FLAGS     <= flg_c;
            ERR       <= err_c;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// tb/tb_cpu_alu_seq.sv - directed self-checking bench for cpu_alu_seq
module tb_cpu_alu_seq;
    import cpu_alu_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic [7:0]    icnt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic [3:0]    flags;
    logic          err;
    logic          busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0]   op;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;

    cpu_alu_seq #(.WIDTH(W)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .A         (a),
        .B         (b),
        .ICNT      (icnt),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT       (out),
        .FLAGS     (flags),
        .ERR       (err),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [7:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        in_valid = 1'b1;
        icnt     = op;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        icnt      = OP_ADD;
        a         = 16'h0001;
        b         = 16'h0001;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if ({out_valid, err, busy, flags, out} !== {1'b0, 1'b0, 1'b0, 4'h0, 16'h0000})
            $display("FAIL reset_state: got v=%b e=%b busy=%b f=%b out=%h, want all zero",
                     out_valid, err, busy, flags, out);
        else passed++;
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_alu_ops;
        vec_t v[14];
        v = '{
            '{OP_ADD, 16'd1,    16'd10,   16'h000B, 4'b0000},
            '{OP_SUB, 16'd10,   16'd1,    16'h0009, 4'b0000},
            '{OP_SUB, 16'd1,    16'd10,   16'hFFF7, 4'b0110},
            '{OP_AND, 16'h000C, 16'h000A, 16'h0008, 4'b0000},
            '{OP_OR,  16'h000C, 16'h000A, 16'h000E, 4'b0000},
            '{OP_XOR, 16'h000C, 16'h000A, 16'h0006, 4'b0000},
            '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101},
            '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010},
            '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001},
            '{OP_SHL, 16'h8001, 16'h0001, 16'h0002, 4'b0010},
            '{OP_SHL, 16'h8000, 16'h0010, 16'h8000, 4'b0100},
            '{OP_SHR, 16'h0003, 16'h0001, 16'h0001, 4'b0010},
            '{OP_SHR, 16'h8000, 16'h000F, 16'h0001, 4'b0000},
            '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b1000}
        };
        total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL pre_accept: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        else passed++;
        for (int i = 0; i < 14; i++) begin
            issue(v[i].op, v[i].av, v[i].bv);
            total++;
            if ({out_valid, err, flags, out} !== {1'b1, 1'b0, v[i].f, v[i].r})
                $display("FAIL alu_vec%0d: got v=%b e=%b f=%b out=%h want v=1 e=0 f=%b out=%h",
                         i, out_valid, err, flags, out, v[i].f, v[i].r);
            else passed++;
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL alu_drain: out_valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_mul;
        vec_t v[4];
        int   busy_cycles;
        logic stray;
        v = '{
            '{OP_MUL, 16'd300,  16'd300,  16'h5F90, 4'b0010},
            '{OP_MUL, 16'h00FF, 16'h0003, 16'h02FD, 4'b0000},
            '{OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1010},
            '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010}
        };
        for (int i = 0; i < 4; i++) begin
            issue(v[i].op, v[i].av, v[i].bv);
            busy_cycles = 0;
            stray       = 1'b0;
            for (int c = 0; c < 16; c++) begin
                if (busy === 1'b1) busy_cycles++;
                if (in_ready !== 1'b0 || out_valid !== 1'b0) stray = 1'b1;
                @(posedge clk);
                #1;
            end
            total++;
            if (busy_cycles != 16) $display("FAIL mul%0d_busy: busy cycles %0d want 16", i, busy_cycles);
            else passed++;
            total++;
            if (stray !== 1'b0) $display("FAIL mul%0d_ready_valid: ready/valid seen high during multiply, want low", i);
            else passed++;
            total++;
            if ({out_valid, busy, err, flags, out} !== {1'b1, 1'b0, 1'b0, v[i].f, v[i].r})
                $display("FAIL mul%0d_result: got v=%b busy=%b e=%b f=%b out=%h want v=1 busy=0 e=0 f=%b out=%h",
                         i, out_valid, busy, err, flags, out, v[i].f, v[i].r);
            else passed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        issue(OP_ADD, 16'h1234, 16'h0001);
        in_valid = 1'b1;
        icnt     = OP_SUB;
        a        = 16'd9;
        b        = 16'd4;
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({out_valid, in_ready, out} !== {1'b1, 1'b0, 16'h1235})
                $display("FAIL stall%0d: got v=%b ready=%b out=%h want v=1 ready=0 out=1235",
                         c, out_valid, in_ready, out);
            else passed++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, flags, out} !== {1'b1, 4'b0000, 16'h0005})
            $display("FAIL b2b_first: got v=%b f=%b out=%h want v=1 f=0000 out=0005", out_valid, flags, out);
        else passed++;
        icnt = OP_ADD;
        a    = 16'd5;
        b    = 16'd5;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, flags, out} !== {1'b1, 4'b0000, 16'h000A})
            $display("FAIL b2b_second: got v=%b f=%b out=%h want v=1 f=0000 out=000a", out_valid, flags, out);
        else passed++;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_illegal;
        issue(8'h03, 16'h0003, 16'h0005);
        total++;
        if ({out_valid, err, flags, out} !== {1'b1, 1'b1, 4'h0, 16'h0000})
            $display("FAIL illegal_03: got v=%b e=%b f=%b out=%h want v=1 e=1 f=0000 out=0000",
                     out_valid, err, flags, out);
        else passed++;
        issue(8'h00, 16'hFFFF, 16'h0001);
        total++;
        if ({out_valid, err, flags, out} !== {1'b1, 1'b1, 4'h0, 16'h0000})
            $display("FAIL illegal_00: got v=%b e=%b f=%b out=%h want v=1 e=1 f=0000 out=0000",
                     out_valid, err, flags, out);
        else passed++;
        issue(8'h81, 16'h0002, 16'h0002);
        total++;
        if ({out_valid, err, busy, flags, out} !== {1'b1, 1'b1, 1'b0, 4'h0, 16'h0000})
            $display("FAIL illegal_81: got v=%b e=%b busy=%b f=%b out=%h want v=1 e=1 busy=0 f=0000 out=0000",
                     out_valid, err, busy, flags, out);
        else passed++;
        issue(OP_AND, 16'hF0F0, 16'hFF00);
        total++;
        if ({out_valid, err, flags, out} !== {1'b1, 1'b0, 4'b0100, 16'hF000})
            $display("FAIL legal_after_illegal: got v=%b e=%b f=%b out=%h want v=1 e=0 f=0100 out=f000",
                     out_valid, err, flags, out);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul;
        logic stray;
        issue(OP_MUL, 16'd300, 16'd300);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({busy, out_valid, in_ready, out} !== {1'b0, 1'b0, 1'b1, 16'h0000})
            $display("FAIL mid_mul_reset: got busy=%b v=%b ready=%b out=%h want busy=0 v=0 ready=1 out=0000",
                     busy, out_valid, in_ready, out);
        else passed++;
        issue(OP_ADD, 16'd2, 16'd3);
        total++;
        if ({out_valid, err, flags, out} !== {1'b1, 1'b0, 4'b0000, 16'h0005})
            $display("FAIL add_after_reset: got v=%b e=%b f=%b out=%h want v=1 e=0 f=0000 out=0005",
                     out_valid, err, flags, out);
        else passed++;
        stray = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) $display("FAIL stale_mul: result or busy appeared after reset aborted multiply");
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
